// File: rtl/rr_arbiter_4_onehot_pkg.sv
// Shared types and helpers for the four-line round-robin arbiter.
package rr_arbiter_4_onehot_pkg;

  localparam int N_LINES = 4;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  function automatic logic [N_LINES-1:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_onehot_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter_4_onehot_if;
  import rr_arbiter_4_onehot_pkg::*;

  logic [N_LINES-1:0] req_lines;
  logic [N_LINES-1:0] grant_lines;
  logic               grant_valid;

  modport master (
    output req_lines,
    input  grant_lines,
    input  grant_valid
  );

  modport slave (
    input  req_lines,
    output grant_lines,
    output grant_valid
  );

endinterface

// File: rtl/rr_arbiter_4_onehot_pick.sv
// Combinational rotating-priority pick: first requester after last_idx wins.
module rr_pick_4
  import rr_arbiter_4_onehot_pkg::*;
(
  input  logic [N_LINES-1:0] req_lines,
  input  logic [1:0]         last_idx,
  output logic               any_req,
  output logic [1:0]         pick_idx
);

  logic [1:0] cand;

  // Scan farthest candidate first so the nearest requester overwrites it.
  always_comb begin
    any_req  = |req_lines;
    pick_idx = last_idx;
    cand     = last_idx;
    for (int k = N_LINES; k >= 1; k--) begin
      cand = last_idx + 2'(k);
      if (req_lines[cand]) begin
        pick_idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4_onehot.sv
// Round-robin arbiter with bounded tenure; grant is registered, one-hot or zero.
module rr_arbiter_4_onehot
  import rr_arbiter_4_onehot_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  rr_arbiter_4_onehot_if.slave bus
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t       state;
  logic [1:0]       owner;
  logic [1:0]       last_idx;
  logic [HOLD_W-1:0] hold_cnt;

  logic       any_req;
  logic [1:0] pick_idx;
  logic       owner_req;
  logic       others_req;

  rr_pick_4 u_pick (
    .req_lines (bus.req_lines),
    .last_idx  (last_idx),
    .any_req   (any_req),
    .pick_idx  (pick_idx)
  );

  assign owner_req  = bus.req_lines[owner];
  assign others_req = |(bus.req_lines & ~idx_to_onehot(owner));

  // Every release or preemption drops to IDLE, forcing a zero-grant gap cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      owner           <= 2'd0;
      last_idx        <= 2'd3;
      hold_cnt        <= '0;
      bus.grant_lines <= '0;
      bus.grant_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner           <= pick_idx;
            hold_cnt        <= '0;
            bus.grant_lines <= idx_to_onehot(pick_idx);
            bus.grant_valid <= 1'b1;
            state           <= GRANT;
          end else begin
            bus.grant_lines <= '0;
            bus.grant_valid <= 1'b0;
          end
        end
        GRANT: begin
          if (!owner_req || ((hold_cnt == HOLD_LAST) && others_req)) begin
            bus.grant_lines <= '0;
            bus.grant_valid <= 1'b0;
            last_idx        <= owner;
            state           <= IDLE;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state           <= IDLE;
          bus.grant_lines <= '0;
          bus.grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4_onehot.sv
// Directed bench for the arbiter: one instance with MAX_HOLD=8, one with MAX_HOLD=4.
module tb_rr_arbiter_4_onehot;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  bit   inv_on;
  logic [3:0] prev_a;
  logic [3:0] prev_b;

  rr_arbiter_4_onehot_if bus_a ();
  rr_arbiter_4_onehot_if bus_b ();

  rr_arbiter_4_onehot #(.MAX_HOLD(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  rr_arbiter_4_onehot #(.MAX_HOLD(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Encoder-safety invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (inv_on) begin
      check("onehot_a", {3'b0, $countones(bus_a.grant_lines) <= 1}, 4'b0001);
      check("valid_a", {3'b0, bus_a.grant_valid}, {3'b0, |bus_a.grant_lines});
      check("nojump_a", {3'b0, (prev_a != 0) && (bus_a.grant_lines != 0) &&
                         (prev_a != bus_a.grant_lines)}, 4'b0000);
      check("onehot_b", {3'b0, $countones(bus_b.grant_lines) <= 1}, 4'b0001);
      check("valid_b", {3'b0, bus_b.grant_valid}, {3'b0, |bus_b.grant_lines});
      check("nojump_b", {3'b0, (prev_b != 0) && (bus_b.grant_lines != 0) &&
                         (prev_b != bus_b.grant_lines)}, 4'b0000);
    end
    prev_a = bus_a.grant_lines;
    prev_b = bus_b.grant_lines;
  end

  logic [3:0] fair_req [12];
  logic [3:0] fair_exp [12];

  initial begin
    total = 0;
    bad   = 0;
    inv_on = 1'b0;
    fair_req = '{4'b1111, 4'b1110, 4'b1111, 4'b1111, 4'b1101, 4'b1111,
                 4'b1111, 4'b1011, 4'b1111, 4'b1111, 4'b0111, 4'b1111};
    fair_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
                 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};

    // Reset with all requests high, then first grant
    reset = 1'b1;
    bus_a.req_lines = 4'b1111;
    bus_b.req_lines = 4'b0000;
    step();
    check("rst0", bus_a.grant_lines, 4'b0000);
    check("rst0_valid", {3'b0, bus_a.grant_valid}, 4'b0000);
    step();
    check("rst1", bus_a.grant_lines, 4'b0000);
    reset = 1'b0;
    step();
    inv_on = 1'b1;
    check("first", bus_a.grant_lines, 4'b0001);
    check("first_valid", {3'b0, bus_a.grant_valid}, 4'b0001);

    // Fairness: each owner drops after two granted cycles
    for (int i = 0; i < 12; i++) begin
      bus_a.req_lines = fair_req[i];
      step();
      check($sformatf("fair%0d", i), bus_a.grant_lines, fair_exp[i]);
    end

    // Release, then sole requester keeps grant indefinitely
    bus_a.req_lines = 4'b0000;
    step();
    check("release", bus_a.grant_lines, 4'b0000);
    bus_a.req_lines = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("sole%0d", i), bus_a.grant_lines, 4'b0100);
    end
    check("hold_sat", {1'b0, dut8.hold_cnt}, 4'b0111);

    // Idle gap preserves last_idx: after owner 2 releases, index 3 is next
    bus_a.req_lines = 4'b0000;
    step();
    check("rel2", bus_a.grant_lines, 4'b0000);
    step();
    check("idle_keep", bus_a.grant_lines, 4'b0000);
    bus_a.req_lines = 4'b1111;
    step();
    check("after_idle", bus_a.grant_lines, 4'b1000);

    // Reset mid-grant with 0010 held
    bus_a.req_lines = 4'b0000;
    step();
    check("rel3", bus_a.grant_lines, 4'b0000);
    bus_a.req_lines = 4'b0010;
    step();
    check("g1", bus_a.grant_lines, 4'b0010);
    bus_a.req_lines = 4'b1010;
    inv_on = 1'b0;
    reset = 1'b1;
    step();
    check("midrst", bus_a.grant_lines, 4'b0000);
    reset = 1'b0;
    step();
    inv_on = 1'b1;
    check("postrst", bus_a.grant_lines, 4'b0010);

    // Preemption on the MAX_HOLD=4 instance: 4 on, 1 gap, alternate owners
    bus_b.req_lines = 4'b0011;
    for (int k = 0; k < 15; k++) begin
      step();
      check($sformatf("preempt%0d", k), bus_b.grant_lines,
            ((k % 5) == 4) ? 4'b0000 : (((k / 5) % 2) == 0) ? 4'b0001 : 4'b0010);
    end

    // Random requests; invariants checked on every falling edge
    for (int i = 0; i < 300; i++) begin
      bus_a.req_lines = 4'($urandom_range(0, 15));
      bus_b.req_lines = 4'($urandom_range(0, 15));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
